// File: rtl/multi_meter.sv
// N-channel averaging meter over MCP3201 SPI ADCs: sums 2**AVG_LOG2 conversions per channel,
// publishes the truncated mean and tracks per-channel peaks. Includes the mcp3201_spi engine.

module mcp3201_spi #(
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 51
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              miso,
  output logic              sclk,
  output logic              cs_n,
  output logic              busy,
  output logic              new_data,
  output logic [DATA_W-1:0] data
);
  // Two sample clocks and a null bit precede the MSB-first data word.
  localparam int FRAME = DATA_W + 3;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int EW    = $clog2(FRAME + 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GUARD} sstate_t;

  sstate_t           state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [EW-1:0]     edges_q, edges_d;
  logic              sclk_q, sclk_d, cs_n_q, cs_n_d, new_data_q, new_data_d;
  logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      edges_q    <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      new_data_q <= 1'b0;
      shift_q    <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      edges_q    <= edges_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      new_data_q <= new_data_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    edges_d    = edges_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    new_data_d = 1'b0;
    shift_d    = shift_q;
    data_d     = data_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_XFER;
        cs_n_d  = 1'b0;
        sclk_d  = 1'b0;
        div_d   = '0;
        edges_d = '0;
      end
      S_XFER: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            // ADC shifts on falling SCLK, so sample on the rising edge.
            sclk_d  = 1'b1;
            shift_d = {shift_q[DATA_W-2:0], miso};
            edges_d = edges_q + 1'b1;
          end else if (edges_q == EW'(FRAME)) begin
            sclk_d     = 1'b0;
            cs_n_d     = 1'b1;
            new_data_d = 1'b1;
            data_d     = shift_q;
            state_d    = S_GUARD;
          end else begin
            sclk_d = 1'b0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GUARD: begin
        // Hold CS high for a half SCLK period before the next frame.
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d   = '0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign busy     = (state_q != S_IDLE);
  assign new_data = new_data_q;
  assign data     = data_q;
endmodule

module multi_meter #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 3,
  parameter int CLK_DIV  = 51
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     continuous,
  input  logic                     peak_clr,
  output logic                     busy,
  output logic                     data_valid,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH*DATA_W-1:0] peak_out,
  input  logic [NUM_CH-1:0]        miso_pin,
  output logic [NUM_CH-1:0]        sclk_pin,
  output logic [NUM_CH-1:0]        cs_pin_n
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int NSAMP = 1 << AVG_LOG2;

  typedef enum logic [2:0] {IDLE, CONVERT, DRAIN, ACCUM, PUBLISH} state_t;

  state_t                         state_q, state_d;
  logic                           busy_q, busy_d, dv_q, dv_d, spi_start_q, spi_start_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [NUM_CH-1:0][ACC_W-1:0]   acc_q, acc_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  sample_q, sample_d, data_q, data_d, peak_q, peak_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  spi_data, avg;
  logic [NUM_CH-1:0]              spi_busy, spi_new;
  logic                           unused_spi;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    mcp3201_spi #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) u_spi (
      .clk      (clk),
      .rst      (rst),
      .start    (spi_start_q),
      .miso     (miso_pin[k]),
      .sclk     (sclk_pin[k]),
      .cs_n     (cs_pin_n[k]),
      .busy     (spi_busy[k]),
      .new_data (spi_new[k]),
      .data     (spi_data[k])
    );
    assign avg[k] = DATA_W'(acc_q[k] >> AVG_LOG2);
  end

  // Engines run in lockstep; channel 0 alone paces the sequence.
  assign unused_spi = ^{spi_new, spi_busy};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      dv_q        <= 1'b0;
      spi_start_q <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      sample_q    <= '0;
      data_q      <= '0;
      peak_q      <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      dv_q        <= dv_d;
      spi_start_q <= spi_start_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sample_q    <= sample_d;
      data_q      <= data_d;
      peak_q      <= peak_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    dv_d        = 1'b0;
    spi_start_d = 1'b0;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sample_d    = sample_q;
    data_d      = data_q;
    peak_d      = peak_clr ? '0 : peak_q;
    case (state_q)
      IDLE: if (start || continuous) begin
        spi_start_d = 1'b1;
        busy_d      = 1'b1;
        state_d     = CONVERT;
      end
      CONVERT: if (spi_new[0]) begin
        sample_d = spi_data;
        state_d  = DRAIN;
      end
      DRAIN: if (!spi_busy[0]) state_d = ACCUM;
      ACCUM: begin
        for (int k = 0; k < NUM_CH; k++) acc_d[k] = acc_q[k] + ACC_W'(sample_q[k]);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NSAMP - 1)) begin
          state_d = PUBLISH;
        end else begin
          spi_start_d = 1'b1;
          state_d     = CONVERT;
        end
      end
      PUBLISH: begin
        // A coincident clear discards the old peak, then the new result loads.
        for (int k = 0; k < NUM_CH; k++) begin
          data_d[k] = avg[k];
          peak_d[k] = (peak_clr || avg[k] > peak_q[k]) ? avg[k] : peak_q[k];
        end
        acc_d = '0;
        cnt_d = '0;
        dv_d  = 1'b1;
        if (continuous) begin
          spi_start_d = 1'b1;
          state_d     = CONVERT;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = busy_q;
  assign data_valid = dv_q;
  assign data_out   = data_q;
  assign peak_out   = peak_q;
endmodule
